// File: rtl/hex_scan_ctrl_if.sv
// Bundles the display-data inputs and the scan outputs of hex_scan_ctrl.
// The datapath side uses the master modport and the scan controller uses the slave modport.
interface hex_scan_ctrl_if #(
    parameter int DIGITS = 4
);
    // Display data produced by the datapath; digit 0 is the rightmost nibble.
    logic [4*DIGITS-1:0] value;
    logic [DIGITS-1:0]   dp_in;
    logic [DIGITS-1:0]   digit_en;
    logic                lz;
    logic                hold;

    // Pins toward the board, plus the frame-boundary strobe.
    logic [DIGITS-1:0]   digit_sel;
    logic [6:0]          segments;
    logic                dp;
    logic                frame_done;

    modport master (
        output value,
        output dp_in,
        output digit_en,
        output lz,
        output hold,
        input  digit_sel,
        input  segments,
        input  dp,
        input  frame_done
    );

    modport slave (
        input  value,
        input  dp_in,
        input  digit_en,
        input  lz,
        input  hold,
        output digit_sel,
        output segments,
        output dp,
        output frame_done
    );
endinterface

// File: rtl/hex_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller.
// One hex decoder is shared by all digit positions. The controller cycles through the positions
// and blanks the display briefly at the start of each slot to stop ghosting. Display data is
// double-buffered and reloaded only at frame boundaries, so a frame never mixes old and new values.
module hex_scan_ctrl #(
    parameter int DIGITS = 4,
    parameter int DIV    = 50000,
    parameter int BLANK  = 500
) (
    input  logic           clk,
    input  logic           rst,
    hex_scan_ctrl_if.slave bus
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IW = $clog2(DIGITS);

    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] BLANK_C  = CW'(BLANK);
    localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);
    localparam logic [IW-1:0] IDX_ONE  = IW'(1);

    // The slot phase is either dark (anti-ghost blanking) or showing the digit.
    localparam logic [0:0] ST_BLANK = 1'b0;
    localparam logic [0:0] ST_SHOW  = 1'b1;
    // With no blanking configured, a slot opens directly in the show phase.
    localparam logic [0:0] ST_SLOT_START = (BLANK == 0) ? ST_SHOW : ST_BLANK;

    logic [CW-1:0]       cnt_q, cnt_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [0:0]          state_q, state_d;
    logic [4*DIGITS-1:0] sh_value_q, sh_value_d;
    logic [DIGITS-1:0]   sh_dp_q, sh_dp_d;
    logic [DIGITS-1:0]   sh_en_q, sh_en_d;
    logic                sh_lz_q, sh_lz_d;
    logic                frame_done_q, frame_done_d;

    logic                slot_end;
    logic                frame_end;
    logic [DIGITS-1:0]   suppress;
    logic                zero_run;
    logic [3:0]          nibble;
    logic                show;

    // Map a hex nibble to segments a..g, with a in bit 6 and g in bit 0.
    function automatic logic [6:0] hex_table(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0:    s = 7'b1111110;
            4'h1:    s = 7'b0110000;
            4'h2:    s = 7'b1101101;
            4'h3:    s = 7'b1111001;
            4'h4:    s = 7'b0110011;
            4'h5:    s = 7'b1011011;
            4'h6:    s = 7'b1011111;
            4'h7:    s = 7'b1110000;
            4'h8:    s = 7'b1111111;
            4'h9:    s = 7'b1111011;
            4'hA:    s = 7'b1110111;
            4'hB:    s = 7'b0011111;
            4'hC:    s = 7'b1001110;
            4'hD:    s = 7'b0111101;
            4'hE:    s = 7'b1001111;
            default: s = 7'b1000111;
        endcase
        return s;
    endfunction

    // Advance the cycle counter within a slot, and step to the next digit position when the slot ends.
    always_comb begin
        slot_end  = (cnt_q == CNT_LAST);
        frame_end = slot_end && (idx_q == IDX_LAST);
        cnt_d     = cnt_q + CNT_ONE;
        idx_d     = idx_q;
        if (slot_end) begin
            cnt_d = '0;
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_ONE;
        end
    end

    // Move from the blanking phase to the show phase when the counter reaches BLANK.
    always_comb begin
        state_d = state_q;
        if (slot_end) begin
            state_d = ST_SLOT_START;
        end else if (cnt_d == BLANK_C) begin
            state_d = ST_SHOW;
        end
    end

    // Sample live inputs into the shadow registers at a frame boundary, unless hold freezes them.
    always_comb begin
        sh_value_d   = sh_value_q;
        sh_dp_d      = sh_dp_q;
        sh_en_d      = sh_en_q;
        sh_lz_d      = sh_lz_q;
        frame_done_d = frame_end;
        if (frame_end && !bus.hold) begin
            sh_value_d = bus.value;
            sh_dp_d    = bus.dp_in;
            sh_en_d    = bus.digit_en;
            sh_lz_d    = bus.lz;
        end
    end

    // Registered scan state. Reset aborts the scan and darkens the display immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            state_q      <= ST_SLOT_START;
            sh_value_q   <= '0;
            sh_dp_q      <= '0;
            sh_en_q      <= '0;
            sh_lz_q      <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            state_q      <= state_d;
            sh_value_q   <= sh_value_d;
            sh_dp_q      <= sh_dp_d;
            sh_en_q      <= sh_en_d;
            sh_lz_q      <= sh_lz_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Leading-zero suppression: a digit above 0 is dark when it and every digit to its left are zero.
    always_comb begin
        zero_run = 1'b1;
        suppress = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            zero_run = zero_run && (sh_value_q[4*i +: 4] == 4'h0);
            if (i > 0) begin
                suppress[i] = sh_lz_q && zero_run;
            end
        end
    end

    // Drive the pins from registered state only: the selected digit, or all dark while blanking or hidden.
    always_comb begin
        nibble         = sh_value_q[{idx_q, 2'b00} +: 4];
        show           = (state_q == ST_SHOW) && sh_en_q[idx_q] && !suppress[idx_q];
        bus.digit_sel  = show ? (DIGITS'(1) << idx_q) : '0;
        bus.segments   = show ? hex_table(nibble) : 7'b0000000;
        bus.dp         = show && sh_dp_q[idx_q];
        bus.frame_done = frame_done_q;
    end

endmodule

// File: tb/tb_hex_scan_ctrl.sv
// Self-checking bench for hex_scan_ctrl with DIGITS=4, DIV=8, BLANK=2.
// The stimulus side pushes one expected output record per clock into a queue.
// Most records come from a small behavioural display model. Spot records carry
// hand-computed literal values instead. A monitor on the falling edge pops each
// record and compares it against the pins.
module tb_hex_scan_ctrl;

    localparam int DIGITS = 4;
    localparam int DIV    = 8;
    localparam int BLANK  = 2;

    typedef struct {
        string    name;
        logic [3:0] sel;
        logic [6:0] seg;
        logic       dp;
        logic       fd;
    } exp_t;

    logic clk;
    logic rst;

    hex_scan_ctrl_if #(.DIGITS(DIGITS)) bus();

    hex_scan_ctrl #(
        .DIGITS(DIGITS),
        .DIV   (DIV),
        .BLANK (BLANK)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Behavioural model of the display state.
    int         m_cnt;
    int         m_idx;
    logic [15:0] m_val;
    logic [3:0]  m_dp;
    logic [3:0]  m_en;
    logic        m_lz;
    logic        m_fd;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hand-written segment patterns for the reference, with a in bit 6 and g in bit 0.
    function automatic logic [6:0] ref_seg(input logic [3:0] n);
        case (n)
            4'h0: return 7'b1111110;
            4'h1: return 7'b0110000;
            4'h2: return 7'b1101101;
            4'h3: return 7'b1111001;
            4'h4: return 7'b0110011;
            4'h5: return 7'b1011011;
            4'h6: return 7'b1011111;
            4'h7: return 7'b1110000;
            4'h8: return 7'b1111111;
            4'h9: return 7'b1111011;
            4'hA: return 7'b1110111;
            4'hB: return 7'b0011111;
            4'hC: return 7'b1001110;
            4'hD: return 7'b0111101;
            4'hE: return 7'b1001111;
            default: return 7'b1000111;
        endcase
    endfunction

    // Return the model to its reset state.
    task automatic model_reset();
        m_cnt = 0;
        m_idx = 0;
        m_val = '0;
        m_dp  = '0;
        m_en  = '0;
        m_lz  = 1'b0;
        m_fd  = 1'b0;
    endtask

    // Apply one rising edge to the model, using the inputs as they stood at that edge.
    task automatic model_edge();
        logic fb;
        if (rst) begin
            model_reset();
        end else begin
            fb   = (m_cnt == DIV - 1) && (m_idx == DIGITS - 1);
            m_fd = fb;
            if (fb && !bus.hold) begin
                m_val = bus.value;
                m_dp  = bus.dp_in;
                m_en  = bus.digit_en;
                m_lz  = bus.lz;
            end
            if (m_cnt == DIV - 1) begin
                m_cnt = 0;
                m_idx = (m_idx + 1) % DIGITS;
            end else begin
                m_cnt = m_cnt + 1;
            end
        end
    endtask

    // Build the expected pin values from the model state.
    task automatic push_model(input string name);
        exp_t e;
        int   highest;
        logic vis;
        highest = -1;
        for (int i = 0; i < DIGITS; i++) begin
            if (m_val[4*i +: 4] != 4'h0) highest = i;
        end
        vis   = m_en[m_idx] && !(m_lz && m_idx > 0 && m_idx > highest);
        e.name = name;
        e.fd   = m_fd;
        e.sel  = '0;
        e.seg  = '0;
        e.dp   = 1'b0;
        if (m_cnt >= BLANK && vis) begin
            e.sel = 4'(1 << m_idx);
            e.seg = ref_seg(m_val[4*m_idx +: 4]);
            e.dp  = m_dp[m_idx];
        end
        exp_q.push_back(e);
    endtask

    function automatic int cur_pos();
        return m_idx * DIV + m_cnt;
    endfunction

    // One clock, with the expectation taken from the model.
    task automatic tick();
        @(posedge clk);
        #1;
        model_edge();
        push_model("scan");
    endtask

    // One clock, with a hand-computed expectation for the cycle after the edge.
    task automatic tick_spot(input string name, input logic [3:0] sel, input logic [6:0] seg,
                             input logic dpv, input logic fd);
        exp_t e;
        @(posedge clk);
        #1;
        model_edge();
        e.name = name;
        e.sel  = sel;
        e.seg  = seg;
        e.dp   = dpv;
        e.fd   = fd;
        exp_q.push_back(e);
    endtask

    task automatic run_until(input int pos);
        for (int k = 0; k < 2 * DIGITS * DIV && cur_pos() != pos; k++) tick();
    endtask

    task automatic run_to_frame_start();
        tick();
        for (int k = 0; k < 2 * DIGITS * DIV && cur_pos() != 0; k++) tick();
    endtask

    task automatic spot_at(input int pos, input string name, input logic [3:0] sel,
                           input logic [6:0] seg, input logic dpv);
        run_until(pos - 1);
        tick_spot(name, sel, seg, dpv, 1'b0);
    endtask

    // Raise reset mid-cycle. This cycle's expectation becomes the dark reset state.
    task automatic reset_mid();
        exp_t dropped;
        #1;
        rst = 1'b1;
        model_reset();
        dropped = exp_q.pop_back();
        push_model("async_reset");
    endtask

    task automatic check_output(input exp_t e);
        n_checks++;
        if (bus.digit_sel === e.sel && bus.segments === e.seg &&
            bus.dp === e.dp && bus.frame_done === e.fd) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: got sel=%b seg=%b dp=%b fd=%b, expected sel=%b seg=%b dp=%b fd=%b",
                     e.name, bus.digit_sel, bus.segments, bus.dp, bus.frame_done,
                     e.sel, e.seg, e.dp, e.fd);
        end
    endtask

    // Monitor: compare the pins against the next queued expectation on every falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check_output(e);
            end
        end
    end

    task automatic apply_stimulus();
        rst          = 1'b1;
        bus.value    = '0;
        bus.dp_in    = '0;
        bus.digit_en = '0;
        bus.lz       = 1'b0;
        bus.hold     = 1'b0;
        model_reset();
        repeat (3) tick();

        // Reset and load: the display stays dark for one frame, then shows 1234.
        rst          = 1'b0;
        bus.value    = 16'h1234;
        bus.digit_en = 4'hF;
        run_until(31);
        tick_spot("first_frame_done", 4'b0000, 7'b0000000, 1'b0, 1'b1);
        spot_at(2,  "slot0_shows_4",  4'b0001, 7'b0110011, 1'b0);
        spot_at(24, "slot3_blank0",   4'b0000, 7'b0000000, 1'b0);
        spot_at(25, "slot3_blank1",   4'b0000, 7'b0000000, 1'b0);
        spot_at(26, "slot3_shows_1",  4'b1000, 7'b0110000, 1'b0);

        // Hold: a mid-frame value change must not reach the display.
        bus.hold = 1'b1;
        run_to_frame_start();
        run_until(13);
        bus.value = 16'hABCD;
        run_to_frame_start();
        spot_at(2,  "hold_keeps_4",   4'b0001, 7'b0110011, 1'b0);
        spot_at(26, "hold_keeps_1",   4'b1000, 7'b0110000, 1'b0);
        bus.hold = 1'b0;
        run_to_frame_start();
        spot_at(2,  "new_d0_D",       4'b0001, 7'b0111101, 1'b0);
        spot_at(10, "new_d1_C",       4'b0010, 7'b1001110, 1'b0);

        // Leading-zero suppression.
        bus.value = 16'h00F0;
        bus.lz    = 1'b1;
        run_to_frame_start();
        spot_at(2,  "lz_d0_0",        4'b0001, 7'b1111110, 1'b0);
        spot_at(10, "lz_d1_F",        4'b0010, 7'b1000111, 1'b0);
        spot_at(18, "lz_d2_dark",     4'b0000, 7'b0000000, 1'b0);
        spot_at(26, "lz_d3_dark",     4'b0000, 7'b0000000, 1'b0);
        bus.value = 16'h0000;
        run_to_frame_start();
        spot_at(2,  "zero_d0_lit",    4'b0001, 7'b1111110, 1'b0);
        spot_at(10, "zero_d1_dark",   4'b0000, 7'b0000000, 1'b0);

        // Digit enables and decimal point.
        bus.value    = 16'h1234;
        bus.lz       = 1'b0;
        bus.digit_en = 4'b0101;
        bus.dp_in    = 4'b0100;
        run_to_frame_start();
        spot_at(2,  "en_d0_4",        4'b0001, 7'b0110011, 1'b0);
        spot_at(10, "en_d1_dark",     4'b0000, 7'b0000000, 1'b0);
        spot_at(18, "en_d2_2_dp",     4'b0100, 7'b1101101, 1'b1);
        spot_at(26, "en_d3_dark",     4'b0000, 7'b0000000, 1'b0);

        // Reset mid-frame while digit 1 is lit.
        bus.digit_en = 4'hF;
        bus.dp_in    = 4'b0000;
        run_to_frame_start();
        run_to_frame_start();
        spot_at(12, "pre_reset_d1_3", 4'b0010, 7'b1111001, 1'b0);
        tick();
        reset_mid();
        tick();
        tick();
        rst = 1'b0;
        spot_at(10, "post_reset_dark", 4'b0000, 7'b0000000, 1'b0);
        spot_at(31, "dark_until_fb",  4'b0000, 7'b0000000, 1'b0);
        tick_spot("fd_after_reset",   4'b0000, 7'b0000000, 1'b0, 1'b1);
        spot_at(2,  "resume_d0_4",    4'b0001, 7'b0110011, 1'b0);
    endtask

    initial begin
        apply_stimulus();
        @(negedge clk);
        #1;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL queue_drained: got %0d pending, expected 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/hex_scan_ctrl.md
# hex_scan_ctrl

Time-multiplexed scan controller for a bank of common-cathode 7-segment digits. A single internal `hex_table` decoder is shared across `DIGITS` digit positions. The controller steps through the positions, selects each digit's nibble into the decoder and drives a one-hot digit enable, with anti-ghosting blanking between slots. Display data is double-buffered so a frame never shows a mix of old and new values. It sits between the datapath that produces the hex values and the board's segment and digit pins.

## Interface
- `DIGITS`, default 4: number of digit positions; range 2..8.
- `DIV`, default 50000: clock cycles per digit slot; must be ≥ 2.
- `BLANK`, default 500: cycles at the start of each slot with the digit dark; 0 ≤ `BLANK` < `DIV`.
- `clk` input 1: single clock; all state updates on its rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `value` input 4*`DIGITS`: hex nibbles; digit i = `value[4i+3:4i]`; digit 0 is rightmost.
- `dp_in` input `DIGITS`: decimal point per digit.
- `digit_en` input `DIGITS`: per-digit enable; 0 keeps that digit dark.
- `lz` input 1: 1 = suppress leading zeros.
- `hold` input 1: 1 = keep the current shadow contents at frame boundaries.
- `digit_sel` output `DIGITS`: one-hot active-high digit enable, or all-zero.
- `segments` output 7: active-high segments; bit 6 = a … bit 0 = g (`hex_table` encoding).
- `dp` output 1: decimal-point segment, active-high.
- `frame_done` output 1: one-cycle pulse at each frame boundary.

## Operation
- **Registered state**
  - `cnt`: width $clog2(`DIV`), counts 0..`DIV`-1.
  - `idx`: counts 0..`DIGITS`-1.
  - Shadow registers: `sh_value`, `sh_dp`, `sh_en`, `sh_lz`.
  - `frame_done` flop.
- **Counters**
  - `cnt` increments every cycle.
  - At `cnt`==`DIV`-1: `cnt`←0 and `idx`←`idx`+1, wrapping from `DIGITS`-1 to 0.
- **Frame boundary (FB):** `cnt`==`DIV`-1 and `idx`==`DIGITS`-1.
  - At the FB edge, if `hold`=0, the shadows load `value`, `dp_in`, `digit_en` and `lz`.
  - If `hold`=1 at the FB, the shadows are unchanged.
  - `frame_done` is 1 for exactly the cycle after each FB edge, regardless of `hold`.
  - Live inputs are sampled only at the FB.
- **Digit visibility:** digit i is visible when `sh_en[i]`=1 and it is not suppressed.
  - With `sh_lz`=1, digit i>0 is suppressed when `sh_value` digits i..`DIGITS`-1 are all zero.
  - Digit 0 is never suppressed.
- **Slot outputs** (decoded combinationally from registered state only; no input-to-output combinational path):
  - Blank phase (`cnt` < `BLANK`) or invisible digit: `digit_sel`=0, `segments`=0, `dp`=0.
  - Otherwise: `digit_sel`=1<<`idx`, `segments`=hex_table(`sh_value` nibble `idx`), `dp`=`sh_dp[idx]`.
- **Slot state machine** (per slot): BLANK (`cnt` < `BLANK`) → SHOW (`cnt` ≥ `BLANK`) → next slot's BLANK. With `BLANK`=0, the slot starts directly in SHOW.
- **Reset** (asynchronous): `cnt`=0, `idx`=0, all shadows=0, `frame_done`=0.
  - Hence `digit_sel`=0, `segments`=0, `dp`=0 until the first FB.
  - Reset asserted mid-slot aborts the scan immediately. The scan resumes at digit 0, `cnt`=0, on the first edge after release.

## Timing
- Slot length is `DIV` cycles; frame length is `DIGITS`*`DIV` cycles.
- The first FB edge after reset release is the `DIGITS`*`DIV`-th rising edge.
- New data is displayed from cycle 0 of digit 0 of the frame following the FB at which it was sampled. Worst-case latency from a `value` change to display is `DIGITS`*`DIV`+`BLANK` cycles.
- `digit_sel` changes only at slot boundaries (`cnt` 0) and at `cnt`==`BLANK`. It never has more than one bit set.
- A `value` change in the same cycle as the FB edge is captured, because the shadows sample on that edge.

## Test plan
Bench parameters: `DIGITS`=4, `DIV`=8, `BLANK`=2.

- **Reset/load:** Reset, then `value`=16'h1234, `digit_en`=4'hF, `lz`=0, `hold`=0.
  - All outputs are 0 for 32 cycles.
  - `frame_done` pulses once.
  - Next frame, cycles 2..7 of slot 0: `digit_sel`=0001, `segments`=7'b0110011 (4). Slot 3 shows 1 = 7'b0110000.
- **Blanking:** In every slot, `digit_sel`=0 for exactly 2 cycles, then one-hot for 6 cycles. `frame_done` period is exactly 32 cycles.
- **Hold/tearing:** Set `hold`=1, change `value` to 16'hABCD mid-frame.
  - The display stays 1234.
  - After `hold`=0, the following frame shows D (7'b0111101) on digit 0.
- **Leading zeros:** `value`=16'h00F0, `lz`=1.
  - Digits 3 and 2 are dark; digit 1 shows F = 7'b1000111; digit 0 shows 0 = 7'b1111110.
  - `value`=0 with `lz`=1: only digit 0 is lit.
- **Enables/dp:** `digit_en`=4'b0101, `dp_in`=4'b0100.
  - Digits 1 and 3 are never selected.
  - `dp`=1 only while `digit_sel`=0100.
- **Reset mid-operation:** Assert `rst` at cycle 13 of a frame.
  - Outputs go to 0 the same cycle (asynchronous).
  - After release, the 32-cycle dark period repeats and the display does not resume until the first FB.
